// File: rtl/pipe_pc_ifid_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg : shared constants and per-cycle action enum for pipeline registers
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ACT_RESET = 2'd0,
    ACT_FLUSH = 2'd1,
    ACT_STALL = 2'd2,
    ACT_ADV   = 2'd3
  } act_e;

endpackage

`default_nettype wire

// File: rtl/pipe_pc_ifid_if.sv
// ---------------------------------------------------------------------------
// pipe_pc_ifid_if : IF-stage inputs, control and ID-stage outputs of the PC/IF-ID block
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pipe_pc_ifid_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      npc_i;
  logic [31:0]      pc4_i;
  logic [31:0]      instruction_i;
  logic             stall_i;
  logic             flush_i;
  logic [31:0]      pc_o;
  logic [31:0]      id_pc_o;
  logic [31:0]      id_pc4_o;
  logic [31:0]      id_instruction_o;
  logic             id_valid_o;
  logic [CNT_W-1:0] fetch_cnt_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output npc_i, pc4_i, instruction_i, stall_i, flush_i,
    input  pc_o, id_pc_o, id_pc4_o, id_instruction_o, id_valid_o,
    input  fetch_cnt_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  npc_i, pc4_i, instruction_i, stall_i, flush_i,
    output pc_o, id_pc_o, id_pc4_o, id_instruction_o, id_valid_o,
    output fetch_cnt_o, stall_cnt_o, flush_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/pipe_pc_ifid_reg.sv
// ---------------------------------------------------------------------------
// pipe_reg : W-bit register with synchronous reset, clear-to-RST_VAL and enable
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_reg #(
  parameter int unsigned    W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         clr,
  input  wire logic         en,
  input  wire logic [W-1:0] d,
  output logic [W-1:0]      q
);

  always_ff @(posedge clk) begin
    if (rst || clr) q <= RST_VAL;
    else if (en)    q <= d;
  end

endmodule

`default_nettype wire

// File: rtl/pipe_pc_ifid.sv
// ---------------------------------------------------------------------------
// pipe_pc_ifid : PC register plus IF/ID pipeline register with stall/flush and
//                fetch/stall/flush event counters
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_pc_ifid
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W    = 32
) (
  input  wire logic       clk,
  input  wire logic       rst,
  pipe_pc_ifid_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  act_e             w_act;
  logic             w_pc_en;
  logic             w_id_en;
  logic             w_id_clr;
  logic [31:0]      w_pc;
  logic [31:0]      w_id_pc;
  logic [31:0]      w_id_pc4;
  logic [31:0]      w_id_instr;
  logic             w_id_valid;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Priority rst > flush > stall > advance
  always_comb begin
    w_act = ACT_ADV;
    if (rst)               w_act = ACT_RESET;
    else if (bus.flush_i)  w_act = ACT_FLUSH;
    else if (bus.stall_i)  w_act = ACT_STALL;
  end

  assign w_pc_en  = (w_act == ACT_ADV) || (w_act == ACT_FLUSH);
  assign w_id_en  = (w_act == ACT_ADV);
  assign w_id_clr = (w_act == ACT_FLUSH);

  pipe_reg #(.W(32), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .clr(1'b0), .en(w_pc_en), .d(bus.npc_i), .q(w_pc)
  );

  pipe_reg #(.W(32), .RST_VAL(32'h0)) u_id_pc (
    .clk(clk), .rst(rst), .clr(w_id_clr), .en(w_id_en), .d(w_pc), .q(w_id_pc)
  );

  pipe_reg #(.W(32), .RST_VAL(32'h0)) u_id_pc4 (
    .clk(clk), .rst(rst), .clr(w_id_clr), .en(w_id_en), .d(bus.pc4_i), .q(w_id_pc4)
  );

  // A flushed slot reads back as NOP so ID decodes a harmless bubble
  pipe_reg #(.W(32), .RST_VAL(NOP_INSTR)) u_id_instr (
    .clk(clk), .rst(rst), .clr(w_id_clr), .en(w_id_en), .d(bus.instruction_i),
    .q(w_id_instr)
  );

  pipe_reg #(.W(1), .RST_VAL(1'b0)) u_id_valid (
    .clk(clk), .rst(rst), .clr(w_id_clr), .en(w_id_en), .d(1'b1), .q(w_id_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (w_act)
        ACT_FLUSH: r_flush_cnt <= r_flush_cnt + CNT_ONE;
        ACT_STALL: r_stall_cnt <= r_stall_cnt + CNT_ONE;
        ACT_ADV:   r_fetch_cnt <= r_fetch_cnt + CNT_ONE;
        default:   ;
      endcase
    end
  end

  assign bus.pc_o             = w_pc;
  assign bus.id_pc_o          = w_id_pc;
  assign bus.id_pc4_o         = w_id_pc4;
  assign bus.id_instruction_o = w_id_instr;
  assign bus.id_valid_o       = w_id_valid;
  assign bus.fetch_cnt_o      = r_fetch_cnt;
  assign bus.stall_cnt_o      = r_stall_cnt;
  assign bus.flush_cnt_o      = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_pc_ifid.sv
// ---------------------------------------------------------------------------
// tb_pipe_pc_ifid : directed plus randomized self-checking bench for pipe_pc_ifid
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipe_pc_ifid;

  localparam int unsigned CNT_W    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_pc_ifid_if #(.CNT_W(CNT_W)) bus ();

  pipe_pc_ifid #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: what the pipeline should hold after each edge
  logic [31:0] m_pc, m_id_pc, m_id_pc4, m_id_instr;
  logic        m_id_valid;
  int          m_fetch, m_stall, m_flush, m_edges;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("pc",        bus.pc_o,             m_pc);
    chk("id_pc",     bus.id_pc_o,          m_id_pc);
    chk("id_pc4",    bus.id_pc4_o,         m_id_pc4);
    chk("id_instr",  bus.id_instruction_o, m_id_instr);
    chk("id_valid",  32'(bus.id_valid_o),  32'(m_id_valid));
    chk("fetch_cnt", 32'(bus.fetch_cnt_o), 32'(m_fetch % 16));
    chk("stall_cnt", 32'(bus.stall_cnt_o), 32'(m_stall % 16));
    chk("flush_cnt", 32'(bus.flush_cnt_o), 32'(m_flush % 16));
  endtask

  // One clock edge: drive inputs, let the edge happen, update the model, check
  task automatic step(input logic r, input logic f, input logic s,
                      input logic [31:0] npc, input logic [31:0] instr);
    logic [31:0] pc4;
    pc4 = m_pc + 32'd4;
    rst               = r;
    bus.flush_i       = f;
    bus.stall_i       = s;
    bus.npc_i         = npc;
    bus.pc4_i         = pc4;
    bus.instruction_i = instr;
    @(posedge clk);
    if (r) begin
      m_pc = RESET_PC; m_id_pc = 0; m_id_pc4 = 0; m_id_instr = 0; m_id_valid = 0;
      m_fetch = 0; m_stall = 0; m_flush = 0; m_edges = 0;
    end else if (f) begin
      m_pc = npc; m_id_pc = 0; m_id_pc4 = 0; m_id_instr = 0; m_id_valid = 0;
      m_flush++; m_edges++;
    end else if (s) begin
      m_stall++; m_edges++;
    end else begin
      m_id_pc = m_pc; m_id_pc4 = pc4; m_id_instr = instr; m_id_valid = 1'b1;
      m_pc = npc; m_fetch++; m_edges++;
    end
    #1;
    check_all();
  endtask

  initial begin
    bus.flush_i = 0; bus.stall_i = 0; bus.npc_i = 0; bus.pc4_i = 0;
    bus.instruction_i = 0;
    m_pc = 0; m_id_pc = 0; m_id_pc4 = 0; m_id_instr = 0; m_id_valid = 0;
    m_fetch = 0; m_stall = 0; m_flush = 0; m_edges = 0;
    #2;

    // Reset for two cycles
    step(1, 0, 0, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    step(1, 0, 0, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    chk("rst_pc_const", bus.pc_o, RESET_PC);

    // Normal flow from PC 0
    step(0, 0, 0, m_pc + 32'd4, 32'h2008_0005);
    chk("first_id_instr", bus.id_instruction_o, 32'h2008_0005);
    chk("first_id_pc4", bus.id_pc4_o, 32'h4);
    step(0, 0, 0, m_pc + 32'd4, 32'h2009_0007);
    chk("pc_at_8", bus.pc_o, 32'h8);

    // Three stalled edges at PC 8, then release
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h0000_0100, 32'h1111_0000 + i);
    chk("stall_cnt_3", 32'(bus.stall_cnt_o), 32'd3);
    step(0, 0, 0, m_pc + 32'd4, 32'h0123_4567);
    chk("after_stall_id_pc", bus.id_pc_o, 32'h8);

    // Flush redirect to 0x40, then capture the instruction there
    step(0, 1, 0, 32'h0000_0040, 32'hBAD0_BAD0);
    chk("flush_pc", bus.pc_o, 32'h40);
    step(0, 0, 0, m_pc + 32'd4, 32'hAAAA_0040);
    chk("after_flush_id_pc", bus.id_pc_o, 32'h40);

    // Stall and flush together: flush wins
    step(0, 1, 1, 32'h0000_0080, 32'hCCCC_CCCC);
    chk("sf_pc", bus.pc_o, 32'h80);
    // Reset together with flush: reset wins
    step(1, 1, 0, 32'h0000_0200, 32'hCCCC_CCCC);

    // Counter wrap: 17 normal edges on a 4-bit counter
    for (int i = 0; i < 17; i++) step(0, 0, 0, m_pc + 32'd4, $urandom);
    chk("fetch_wrap", 32'(bus.fetch_cnt_o), 32'h1);

    // Random mix, including unaligned redirect targets and occasional reset
    for (int i = 0; i < 300; i++) begin
      int unsigned sel;
      logic [31:0] npc;
      sel = $urandom_range(0, 99);
      npc = (sel[0]) ? $urandom : m_pc + 32'd4;
      step(sel == 0, sel inside {[1:25]}, sel inside {[15:50]}, npc, $urandom);
    end
    chk("counter_sum", 32'((bus.fetch_cnt_o + bus.stall_cnt_o + bus.flush_cnt_o) & 4'hF),
        32'(m_edges % 16));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout got running exp finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
